mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sole owner of the byte-wide RAM/IO port. Shares it between the instruction fetcher
//  (multi-word line bursts) and the load/store buffer (1/2/4-byte accesses). Serialises
//  accesses into byte transfers, assembles little-endian words, and aborts fetch bursts
//  on ROB rollback. Sits between fetcher/LSB and the top-level mem_* pins.
// PARAMETERS
//  LINE_WORDS  4   words per fetch burst (1..8); burst length = LINE_WORDS*4 bytes
//  ADDR_W      32  address width of all address ports
// PORTS
//  clk_in           in   1       clock
//  rst_in           in   1       reset, asynchronous, active-high
//  rdy_in           in   1       global enable; low = freeze all state
//  rollback_in      in   1       ROB rollback pulse
//  if_req_in        in   1       fetch request (level; held until if_done_out)
//  if_addr_in       in   ADDR_W  fetch line start address (word aligned)
//  if_word_valid_out out 1       one-cycle pulse: if_data_out/if_word_addr_out valid
//  if_data_out      out  32      assembled instruction word
//  if_word_addr_out out  ADDR_W  address of if_data_out
//  if_done_out      out  1       one-cycle pulse with last word of burst
//  ls_req_in        in   1       LSB request (level; held until ls_done_out)
//  ls_wr_in         in   1       1 = store, 0 = load
//  ls_size_in       in   2       0 byte, 1 half, 2 word, 3 treated as word
//  ls_addr_in       in   ADDR_W  access address
//  ls_wdata_in      in   32      store data, low bytes first
//  ls_rdata_out     out  32      load data, zero-extended, valid with ls_done_out
//  ls_done_out      out  1       one-cycle completion pulse
//  mem_din          in   8       RAM/IO read byte (for address of previous cycle)
//  mem_dout         out  8       write byte
//  mem_a            out  ADDR_W  byte address
//  mem_wr           out  1       1 = write
//  io_buffer_full   in   1       UART output buffer full
//  busy_out         out  1       high in any state but IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; mem_wr 0; assembly registers cleared.
//  States: IDLE -> {IF_RD, LS_RD, LS_WR} -> DONE -> IDLE.
//  IDLE grant: ls_req_in wins over if_req_in (fixed priority); grant edge = t.
//  n = bytes (LS: 1/2/4, IF: LINE_WORDS*4). Byte i: mem_a = base+i registered at edge
//   t+i, address arithmetic mod 2^ADDR_W (wraps past 0xFFFFFFFF).
//  Read: byte i captured from mem_din at edge t+i+2 into lane i%4. LS_RD: ls_done_out
//   and ls_rdata_out registered at edge t+n+1. IF_RD: if_word_valid_out at edge after
//   every 4th capture, if_word_addr_out = base+4k; if_done_out with word LINE_WORDS-1.
//  Write: mem_wr=1, mem_dout = ls_wdata_in byte i at edge t+i; mem_wr=0 and
//   ls_done_out=1 at edge t+n.
//  Completion enters DONE (1 cycle, requests ignored) so requester deasserts req.
//  Pulses (*_valid_out, *_done_out) last exactly one cycle; data outs hold until next pulse.
//  Bursts never preempted by LSB; LS waits until IF burst completes or aborts.
//  rollback_in in IF_RD: no further address/word pulses; next state IDLE; in-flight byte
//   discarded; no if_done_out. In IDLE: clears pending IF grant that edge.
//  rollback_in in LS_RD/LS_WR: ignored; transaction completes, ls_done_out still pulses.
//  rdy_in low: state, counters, outputs held; mem_wr forced 0 combinationally; capture
//   suppressed and the pending byte re-read (re-issue same mem_a) when rdy_in returns.
//  Async reset mid-transaction: immediate return to IDLE, mem_wr deasserts at once.
// CONFIGURATION
//  MEM_ARB_IO_STALL_EN defined: LS_WR with ls_addr_in[17:16]==2'b11 not granted while
//   io_buffer_full=1; IF may be granted meanwhile. Undefined: io_buffer_full ignored.
// TESTING
//  LS load word @0x1000, RAM 11 22 33 44 -> ls_rdata_out 0x44332211, done at edge t+5.
//  LS store half 0xBEEF @0x2002 -> mem_wr writes EF@0x2002, BE@0x2003, done at t+2.
//  IF burst @0x0 (LINE_WORDS=4) -> 4 word pulses addr 0,4,8,C, if_done_out with 4th.
//  Same-cycle if_req+ls_req -> LSB served first; IF grant follows DONE cycle.
//  rollback_in at edge t+6 of IF burst -> one word pulse only, IDLE next, no if_done_out.
//  IO_STALL_EN: store @0x30000 with io_buffer_full=1 for 10 cycles -> no mem_wr; write
//   starts edge after full drops.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Fetcher, load/store buffer and RAM/IO pin bundle of the memory arbiter.
// The arbiter uses the slave modport; clients and the memory use master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_in;
    logic [ADDR_W-1:0] if_addr_in;
    logic              if_word_valid_out;
    logic [31:0]       if_data_out;
    logic [ADDR_W-1:0] if_word_addr_out;
    logic              if_done_out;

    logic              ls_req_in;
    logic              ls_wr_in;
    logic [1:0]        ls_size_in;
    logic [ADDR_W-1:0] ls_addr_in;
    logic [31:0]       ls_wdata_in;
    logic [31:0]       ls_rdata_out;
    logic              ls_done_out;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  if_req_in, if_addr_in,
        output if_word_valid_out, if_data_out, if_word_addr_out, if_done_out,
        input  ls_req_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in,
        output ls_rdata_out, ls_done_out,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req_in, if_addr_in,
        input  if_word_valid_out, if_data_out, if_word_addr_out, if_done_out,
        output ls_req_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in,
        input  ls_rdata_out, ls_done_out,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: fetch line bursts and LSB 1/2/4-byte accesses.
// Optional MEM_ARB_IO_STALL_EN holds IO-window stores while the UART buffer is full.
//
// state | meaning
// IDLE  | no transfer; grants LSB over fetcher
// IF_RD | fetch burst, LINE_WORDS*4 bytes
// LS_RD | LSB load, 1/2/4 bytes
// LS_WR | LSB store, 1/2/4 bytes
// DONE  | one cycle for the requester to drop its request
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          rollback_in,
    output logic          busy_out,
    mem_arbiter_if.slave  bus
);
    localparam int IF_BYTES = LINE_WORDS * 4;

    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q, mem_a_q, if_word_addr_q;
    logic [5:0]        n_q, a_cnt, c_cnt, ls_n;
    logic [31:0]       wdata_q, asm_q, asm_nx, if_data_q, ls_rdata_q;
    logic [7:0]        mem_dout_q;
    logic              iss_v, p1, stall_q, word_pend, mem_wr_q;
    logic              if_word_valid_q, if_done_q, ls_done_q;
    logic              grant_ls, grant_if, ls_blocked, cap_en, last_word;
    logic [3:0]        word_idx;

    function automatic logic [ADDR_W-1:0] off(input logic [5:0] c);
        return {{(ADDR_W-6){1'b0}}, c};
    endfunction

`ifdef MEM_ARB_IO_STALL_EN
    assign ls_blocked = bus.ls_wr_in && (bus.ls_addr_in[17:16] == 2'b11) && bus.io_buffer_full;
`else
    logic unused_io;
    assign unused_io  = bus.io_buffer_full;
    assign ls_blocked = 1'b0;
`endif

    always_comb begin
        case (bus.ls_size_in)
            2'd0:    ls_n = 6'd1;
            2'd1:    ls_n = 6'd2;
            default: ls_n = 6'd4;
        endcase
    end

    // Capture is suppressed on the first edge after a freeze: the byte is re-read instead.
    assign cap_en    = p1 && !stall_q;
    assign word_idx  = c_cnt[5:2] - 4'd1;
    assign last_word = (word_idx == 4'(LINE_WORDS - 1));

    always_comb begin
        asm_nx = asm_q;
        asm_nx[{c_cnt[1:0], 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (bus.ls_req_in && !ls_blocked) begin
                        grant_ls = 1'b1;
                        state_nx = bus.ls_wr_in ? LS_WR : LS_RD;
                    end else if (bus.if_req_in && !rollback_in) begin
                        grant_if = 1'b1;
                        state_nx = IF_RD;
                    end
                end
                IF_RD: begin
                    if (rollback_in)                 state_nx = IDLE;
                    else if (word_pend && last_word) state_nx = DONE;
                end
                LS_RD:   if (cap_en && c_cnt == n_q - 6'd1) state_nx = DONE;
                LS_WR:   if (a_cnt == n_q) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            base_q <= '0; mem_a_q <= '0; if_word_addr_q <= '0;
            n_q <= '0; a_cnt <= '0; c_cnt <= '0;
            wdata_q <= '0; asm_q <= '0; if_data_q <= '0; ls_rdata_q <= '0;
            mem_dout_q <= '0; mem_wr_q <= 1'b0;
            iss_v <= 1'b0; p1 <= 1'b0; stall_q <= 1'b0; word_pend <= 1'b0;
            if_word_valid_q <= 1'b0; if_done_q <= 1'b0; ls_done_q <= 1'b0;
        end else if (!rdy_in) begin
            stall_q <= 1'b1;
        end else begin
            stall_q         <= 1'b0;
            if_word_valid_q <= 1'b0;
            if_done_q       <= 1'b0;
            ls_done_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        base_q    <= grant_ls ? bus.ls_addr_in : bus.if_addr_in;
                        mem_a_q   <= grant_ls ? bus.ls_addr_in : bus.if_addr_in;
                        n_q       <= grant_ls ? ls_n : 6'(IF_BYTES);
                        wdata_q   <= bus.ls_wdata_in;
                        asm_q     <= '0;
                        a_cnt     <= 6'd1;
                        c_cnt     <= '0;
                        p1        <= 1'b0;
                        word_pend <= 1'b0;
                        iss_v     <= !(grant_ls && bus.ls_wr_in);
                        if (grant_ls && bus.ls_wr_in) begin
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= bus.ls_wdata_in[7:0];
                        end
                    end
                end
                LS_WR: begin
                    if (a_cnt == n_q) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                    end else begin
                        mem_a_q    <= base_q + off(a_cnt);
                        mem_dout_q <= wdata_q[{a_cnt[1:0], 3'b000} +: 8];
                        a_cnt      <= a_cnt + 6'd1;
                    end
                end
                IF_RD, LS_RD: begin
                    if (state == IF_RD && rollback_in) begin
                        iss_v <= 1'b0;
                        p1    <= 1'b0;
                    end else if (stall_q) begin
                        // mem_din went stale during the freeze: restart from the first uncaptured byte.
                        if (c_cnt < n_q) begin
                            mem_a_q <= base_q + off(c_cnt);
                            a_cnt   <= c_cnt + 6'd1;
                            iss_v   <= 1'b1;
                        end else begin
                            iss_v <= 1'b0;
                        end
                        p1 <= 1'b0;
                    end else begin
                        if (a_cnt < n_q) begin
                            mem_a_q <= base_q + off(a_cnt);
                            a_cnt   <= a_cnt + 6'd1;
                            iss_v   <= 1'b1;
                        end else begin
                            iss_v <= 1'b0;
                        end
                        p1 <= iss_v;
                        if (p1) begin
                            asm_q <= asm_nx;
                            c_cnt <= c_cnt + 6'd1;
                            if (state == LS_RD && c_cnt == n_q - 6'd1) begin
                                ls_rdata_q <= asm_nx;
                                ls_done_q  <= 1'b1;
                            end
                        end
                    end
                    if (state == IF_RD) begin
                        if (word_pend) begin
                            if_word_valid_q <= 1'b1;
                            if_data_q       <= asm_q;
                            if_word_addr_q  <= base_q + off({word_idx, 2'b00});
                            if_done_q       <= last_word && !rollback_in;
                        end
                        word_pend <= !rollback_in && cap_en && (c_cnt[1:0] == 2'b11);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out              = (state != IDLE);
    assign bus.mem_a             = mem_a_q;
    assign bus.mem_dout          = mem_dout_q;
    assign bus.mem_wr            = mem_wr_q & rdy_in;
    assign bus.if_word_valid_out = if_word_valid_q;
    assign bus.if_data_out       = if_data_q;
    assign bus.if_word_addr_out  = if_word_addr_q;
    assign bus.if_done_out       = if_done_q;
    assign bus.ls_rdata_out      = ls_rdata_q;
    assign bus.ls_done_out       = ls_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven LSB accesses, fetch bursts,
// priority, rollback, rdy freeze, async reset and IO stall (when MEM_ARB_IO_STALL_EN).
module tb_mem_arbiter;
    localparam int AW = 32;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic rollback_in = 1'b0;
    logic busy_out;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_arbiter #(.LINE_WORDS(4), .ADDR_W(AW)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rollback_in (rollback_in),
        .busy_out    (busy_out),
        .bus         (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM model: unwritten bytes read as addr[7:0]^A5; mem_din is one cycle behind mem_a.
    byte unsigned ram_q [bit [31:0]];
    function automatic logic [7:0] ram_rd(input bit [31:0] a);
        if (ram_q.exists(a)) return ram_q[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk_in) begin
        if (bus.mem_wr === 1'b1) ram_q[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= ram_rd(bus.mem_a);
    end

    typedef struct packed { logic [31:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic is_load; logic [31:0] rdata; } ls_exp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic last; } ifw_t;
    wr_t     exp_wr_q [$];
    ls_exp_t exp_ls_q [$];
    ifw_t    exp_if_q [$];
    int if_words = 0, if_dones = 0;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (bus.mem_wr === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%02h, none required", bus.mem_a, bus.mem_dout);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", bus.mem_a, w.addr);
                    chk("wr_data", {24'h0, bus.mem_dout}, {24'h0, w.data});
                end
            end
            if (bus.ls_done_out === 1'b1) begin
                if (exp_ls_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ls_done: rdata 0x%08h, no transaction pending", bus.ls_rdata_out);
                end else begin
                    ls_exp_t e;
                    e = exp_ls_q.pop_front();
                    if (e.is_load) chk("ls_rdata", bus.ls_rdata_out, e.rdata);
                end
            end
            if (bus.if_done_out === 1'b1) if_dones++;
            if (bus.if_word_valid_out === 1'b1) begin
                if_words++;
                if (exp_if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_if_word: addr 0x%08h data 0x%08h", bus.if_word_addr_out, bus.if_data_out);
                end else begin
                    ifw_t f;
                    f = exp_if_q.pop_front();
                    chk("if_word_addr", bus.if_word_addr_out, f.addr);
                    chk("if_data", bus.if_data_out, f.data);
                    chk("if_done_with_word", {31'h0, bus.if_done_out}, {31'h0, f.last});
                end
            end else begin
                chk("if_done_without_word", {31'h0, bus.if_done_out}, 32'h0);
            end
        end
    end

    // Line at 0x0 from the unwritten-RAM pattern addr^A5.
    logic [31:0] line0 [4];
    task automatic push_line0(input int words);
        for (int k = 0; k < words; k++)
            exp_if_q.push_back({32'(4 * k), line0[k], (k == 3)});
    endtask

    task automatic push_writes(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) exp_wr_q.push_back({addr + 32'(i), wdata[8*i +: 8]});
    endtask

    task automatic wait_done(input bit is_if, input int limit, output int cyc, output bit seen);
        cyc = 0; seen = 0;
        while (!seen && cyc < limit) begin
            @(posedge clk_in); #1;
            cyc++;
            if ((is_if ? bus.if_done_out : bus.ls_done_out) === 1'b1) seen = 1;
        end
    endtask

    task automatic ls_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
        int n, cyc;
        bit seen;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_ls_q.push_back({!wr, exp_rdata});
        if (wr) push_writes(size, addr, wdata);
        @(negedge clk_in);
        bus.ls_req_in = 1; bus.ls_wr_in = wr; bus.ls_size_in = size;
        bus.ls_addr_in = addr; bus.ls_wdata_in = wdata;
        wait_done(0, 60, cyc, seen);
        chk("ls_done_seen", {31'h0, seen}, 32'h1);
        chk("ls_latency", cyc, wr ? n + 1 : n + 2);
        bus.ls_req_in = 0;
        @(posedge clk_in); #1;
        chk("ls_done_pulse", {31'h0, bus.ls_done_out}, 32'h0);
        chk("ls_idle_after_done", {31'h0, busy_out}, 32'h0);
        if (!wr) chk("ls_rdata_hold", bus.ls_rdata_out, exp_rdata);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } ls_vec_t;
    ls_vec_t vecs [10];

    initial begin
        int cyc, w0, d0;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, w0, d0;
        bit seen;

        line0[0] = 32'hA6A7A4A5; line0[1] = 32'hA2A3A0A1;
        line0[2] = 32'hAEAFACAD; line0[3] = 32'hAAABA8A9;
        ram_q[32'h1000] = 8'h11; ram_q[32'h1001] = 8'h22;
        ram_q[32'h1002] = 8'h33; ram_q[32'h1003] = 8'h44;

        vecs[0] = '{0, 2'd2, 32'h0000_1000, 32'h0,         32'h4433_2211};
        vecs[1] = '{1, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0};
        vecs[2] = '{0, 2'd1, 32'h0000_2002, 32'h0,         32'h0000_BEEF};
        vecs[3] = '{0, 2'd0, 32'h0000_1003, 32'h0,         32'h0000_0044};
        vecs[4] = '{1, 2'd2, 32'h0000_3000, 32'hCAFE_F00D, 32'h0};
        vecs[5] = '{0, 2'd2, 32'h0000_3000, 32'h0,         32'hCAFE_F00D};
        vecs[6] = '{0, 2'd3, 32'h0000_1000, 32'h0,         32'h4433_2211};
        vecs[7] = '{1, 2'd0, 32'h0000_4001, 32'h1234_5678, 32'h0};
        vecs[8] = '{0, 2'd2, 32'h0000_4000, 32'h0,         32'hA6A7_78A5};
        vecs[9] = '{0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hA4A5_5A5B};

        bus.if_req_in = 0; bus.if_addr_in = '0;
        bus.ls_req_in = 0; bus.ls_wr_in = 0; bus.ls_size_in = 0;
        bus.ls_addr_in = '0; bus.ls_wdata_in = '0; bus.io_buffer_full = 0;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", {31'h0, busy_out}, 32'h0);
        chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_dout", {24'h0, bus.mem_dout}, 32'h0);
        chk("rst_ls_done", {31'h0, bus.ls_done_out}, 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata_out, 32'h0);
        chk("rst_if_valid", {31'h0, bus.if_word_valid_out}, 32'h0);
        chk("rst_if_done", {31'h0, bus.if_done_out}, 32'h0);
        chk("rst_if_data", bus.if_data_out, 32'h0);
        @(negedge clk_in) rst_in = 0;
        repeat (2) @(posedge clk_in);

        for (int i = 0; i < 10; i++)
            ls_txn(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // fetch burst at 0x0: last word pulse at grant edge + 18
        w0 = if_words; d0 = if_dones;
        push_line0(4);
        @(negedge clk_in);
        bus.if_req_in = 1; bus.if_addr_in = 32'h0;
        wait_done(1, 100, cyc, seen);
        chk("if_done_seen", {31'h0, seen}, 32'h1);
        chk("if_latency", cyc, 19);
        bus.if_req_in = 0;
        @(posedge clk_in); #1;
        chk("if_done_pulse", {31'h0, bus.if_done_out}, 32'h0);
        chk("if_idle_after", {31'h0, busy_out}, 32'h0);
        chk("if_word_hold", bus.if_data_out, line0[3]);
        chk("if_word_count", if_words - w0, 4);
        chk("if_done_count", if_dones - d0, 1);

        // same-cycle requests: LSB first, fetch after
        w0 = if_words;
        exp_ls_q.push_back({1'b1, 32'h4433_2211});
        push_line0(4);
        @(negedge clk_in);
        bus.ls_req_in = 1; bus.ls_wr_in = 0; bus.ls_size_in = 2; bus.ls_addr_in = 32'h1000;
        bus.if_req_in = 1; bus.if_addr_in = 32'h0;
        wait_done(0, 60, cyc, seen);
        chk("prio_ls_done_seen", {31'h0, seen}, 32'h1);
        chk("prio_ls_latency", cyc, 6);
        chk("prio_no_if_before_ls", if_words - w0, 0);
        bus.ls_req_in = 0;
        wait_done(1, 100, cyc, seen);
        chk("prio_if_done_seen", {31'h0, seen}, 32'h1);
        bus.if_req_in = 0;
        repeat (2) @(posedge clk_in);
        chk("prio_if_word_count", if_words - w0, 4);

        // rollback sampled at grant edge + 6: one word, no done, IDLE
        w0 = if_words; d0 = if_dones;
        push_line0(1);
        @(negedge clk_in);
        bus.if_req_in = 1; bus.if_addr_in = 32'h0;
        repeat (6) @(posedge clk_in);
        @(negedge clk_in) rollback_in = 1;
        @(posedge clk_in); #1;
        chk("rb_idle", {31'h0, busy_out}, 32'h0);
        @(negedge clk_in);
        rollback_in = 0; bus.if_req_in = 0;
        repeat (30) @(posedge clk_in);
        #1;
        chk("rb_word_count", if_words - w0, 1);
        chk("rb_no_done", if_dones - d0, 0);
        chk("rb_still_idle", {31'h0, busy_out}, 32'h0);

        // rdy freeze during a load: pending bytes re-read on resume
        exp_ls_q.push_back({1'b1, 32'h4433_2211});
        @(negedge clk_in);
        bus.ls_req_in = 1; bus.ls_wr_in = 0; bus.ls_size_in = 2; bus.ls_addr_in = 32'h1000;
        repeat (2) @(posedge clk_in);
        #1 rdy_in = 0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("stall_ld_no_done", {31'h0, bus.ls_done_out}, 32'h0);
        chk("stall_ld_busy", {31'h0, busy_out}, 32'h1);
        rdy_in = 1;
        wait_done(0, 60, cyc, seen);
        chk("stall_ld_done_seen", {31'h0, seen}, 32'h1);
        bus.ls_req_in = 0;
        repeat (2) @(posedge clk_in);

        // rdy freeze during a store: mem_wr gated at once, each byte written once
        exp_ls_q.push_back({1'b0, 32'h0});
        push_writes(2'd2, 32'h5000, 32'h1122_3344);
        @(negedge clk_in);
        bus.ls_req_in = 1; bus.ls_wr_in = 1; bus.ls_size_in = 2;
        bus.ls_addr_in = 32'h5000; bus.ls_wdata_in = 32'h1122_3344;
        repeat (2) @(posedge clk_in);
        #1;
        chk("stall_wr_active", {31'h0, bus.mem_wr}, 32'h1);
        rdy_in = 0;
        #1;
        chk("stall_wr_gated", {31'h0, bus.mem_wr}, 32'h0);
        repeat (2) @(posedge clk_in);
        #1 rdy_in = 1;
        wait_done(0, 60, cyc, seen);
        chk("stall_wr_done_seen", {31'h0, seen}, 32'h1);
        bus.ls_req_in = 0;
        repeat (2) @(posedge clk_in);
        ls_txn(0, 2'd2, 32'h5000, 32'h0, 32'h1122_3344);

        // store wrapping past 0xFFFFFFFF
        ls_txn(1, 2'd2, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0);
        ls_txn(0, 2'd2, 32'h0000_0000, 32'h0, 32'hA6010203);

`ifdef MEM_ARB_IO_STALL_EN
        exp_ls_q.push_back({1'b0, 32'h0});
        push_writes(2'd2, 32'h0003_0000, 32'hDEAD_BEEF);
        bus.io_buffer_full = 1;
        @(negedge clk_in);
        bus.ls_req_in = 1; bus.ls_wr_in = 1; bus.ls_size_in = 2;
        bus.ls_addr_in = 32'h0003_0000; bus.ls_wdata_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            chk("io_stall_no_wr", {31'h0, bus.mem_wr}, 32'h0);
        end
        @(negedge clk_in) bus.io_buffer_full = 0;
        @(posedge clk_in); #1;
        chk("io_stall_wr_starts", {31'h0, bus.mem_wr}, 32'h1);
        wait_done(0, 60, cyc, seen);
        chk("io_stall_done_seen", {31'h0, seen}, 32'h1);
        bus.ls_req_in = 0;
        repeat (2) @(posedge clk_in);
`else
        bus.io_buffer_full = 1;
        ls_txn(1, 2'd2, 32'h0003_0000, 32'hDEAD_BEEF, 32'h0);
        bus.io_buffer_full = 0;
`endif

        // async reset in the middle of a store
        exp_ls_q.push_back({1'b0, 32'h0});
        exp_wr_q.push_back({32'h6000, 8'h44});
        exp_wr_q.push_back({32'h6001, 8'h33});
        @(negedge clk_in);
        bus.ls_req_in = 1; bus.ls_wr_in = 1; bus.ls_size_in = 2;
        bus.ls_addr_in = 32'h6000; bus.ls_wdata_in = 32'h1122_3344;
        repeat (3) @(posedge clk_in);
        #2 rst_in = 1;
        #1;
        chk("arst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("arst_busy", {31'h0, busy_out}, 32'h0);
        bus.ls_req_in = 0;
        void'(exp_ls_q.pop_back());
        @(negedge clk_in) rst_in = 0;
        repeat (3) @(posedge clk_in);

        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("ls_queue_drained", exp_ls_q.size(), 0);
        chk("if_queue_drained", exp_if_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
